// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared constants and FSM encoding for the SRAM family
package sram_pkg;

    localparam int BYTE_W = 8;

    // Collision behaviour selector values for the BYPASS parameter
    localparam int BYPASS_READ_FIRST    = 0;
    localparam int BYPASS_WRITE_THROUGH = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

endpackage

// File: rtl/sram_read_pipe.sv
// rtl/sram_read_pipe.sv - LATENCY-deep valid/data register chain for read results
// Ports: clk, rst_n (async active-low); in_valid/in_data enter stage 0;
//        out_valid/out_data leave the last stage. Data in a stage only
//        changes when a valid word moves into it, so the output holds
//        its last value between reads.
module sram_read_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]            valid_q;
    logic [LATENCY-1:0]            valid_d;
    logic [LATENCY-1:0]            stage_in_valid;
    logic [LATENCY-1:0][WIDTH-1:0] data_q;
    logic [LATENCY-1:0][WIDTH-1:0] data_d;
    logic [LATENCY-1:0][WIDTH-1:0] stage_in_data;

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_in_valid[g] = in_valid;
            assign stage_in_data[g]  = in_data;
        end else begin : g_tail
            assign stage_in_valid[g] = valid_q[g-1];
            assign stage_in_data[g]  = data_q[g-1];
        end
    end

    always_comb begin
        valid_d = '0;
        data_d  = '0;
        for (int i = 0; i < LATENCY; i++) begin
            valid_d[i] = stage_in_valid[i];
            data_d[i]  = stage_in_valid[i] ? stage_in_data[i] : data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/dual_port_sram.sv
// rtl/dual_port_sram.sv - simple dual-port SRAM with byte enables and zero-init sweep
// Ports: clk, rst_n (async active-low);
//        write port wr_en/wr_addr/wr_data/wr_be;
//        read port rd_en/rd_addr -> rd_data/rd_valid after READ_LATENCY cycles;
//        init_done high once the post-reset clear sweep has finished.
module dual_port_sram
    import sram_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 2,
    parameter int BYPASS       = 1,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int BE_WIDTH     = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  init_done
);

    // One extra bit so a non-power-of-two DEPTH compares without truncation
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    sram_state_e           state_q;
    sram_state_e           state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    logic                  clear_we;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [WIDTH-1:0]      rd_word;

    logic [WIDTH-1:0]      mem [DEPTH];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // FSM next state: CLEAR walks ptr over every word, READY is terminal
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        clear_we  = (state_q == ST_CLEAR);
        init_done = (state_q == ST_READY);
    end

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign wr_fire     = init_done && wr_en && wr_in_range;
    assign rd_fire     = init_done && rd_en;

    // Read word; in write-through mode a same-address write is merged in
    // lane by lane so the reader sees what the array will hold after the edge
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
        end
        if (BYPASS == BYPASS_WRITE_THROUGH && wr_fire && (wr_addr == rd_addr)) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (wr_be[k]) begin
                    rd_word[k*BYTE_W +: BYTE_W] = wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Storage has no reset; the clear sweep is the only initialisation
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[ptr_q] <= '0;
        end else if (wr_fire) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    sram_read_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: doc/dual_port_sram.md
# dual_port_sram

Parametrised simple-dual-port SRAM: one write port with byte enables and one independent read port, both on a single clock. It replaces the single-port, tri-state-bus SRAM in designs that need concurrent read and write. It adds a configurable read latency, a read-valid strobe, defined read/write collision behaviour, and a hardware zero-initialisation sweep after reset. It sits between datapath producers and consumers as on-chip buffer storage.

## Interface
- WIDTH, 32, data word width in bits; must be a multiple of 8
- DEPTH, 16, number of words; need not be a power of two
- READ_LATENCY, 2, cycles from sampled rd_en to rd_valid; legal values 1 or 2
- BYPASS, 1, collision mode: 1 = write-through (new data), 0 = read-first (old data)
- Derived: ADDR_WIDTH = $clog2(DEPTH); BE_WIDTH = WIDTH/8
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  WIDTH  write data
- wr_be  in  BE_WIDTH  byte enables; bit k covers wr_data[8k+7:8k]
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  WIDTH  read data; valid when rd_valid=1
- rd_valid  out  1  rd_data carries the result of the read issued READ_LATENCY cycles earlier
- init_done  out  1  zero-initialisation sweep finished; ports are accepted only when this is 1

## Operation
- Reset asserted: rd_data=0, rd_valid=0, init_done=0, the latency pipeline is flushed, and the FSM enters CLEAR with the clear pointer at 0.
- FSM has two states:
  - CLEAR: writes all-zero to mem[ptr] each cycle and increments ptr. When ptr = DEPTH-1 is written, it moves to READY and sets init_done=1 on the next edge. A full sweep takes DEPTH cycles after reset release.
  - READY: terminal state; it is left only by reset. Reset mid-CLEAR restarts the sweep at address 0.
- While in CLEAR, wr_en and rd_en are ignored. No write occurs and no rd_valid is produced.
- Write: if init_done, wr_en=1 and wr_addr < DEPTH, each byte lane with wr_be[k]=1 is updated. Lanes with wr_be[k]=0 keep their value. wr_be=0 is a no-op.
- Read: if init_done and rd_en=1, the read is issued. rd_addr >= DEPTH returns 0 and still produces rd_valid.
- Collision (same cycle, wr_en and rd_en both accepted, wr_addr == rd_addr):
  - BYPASS=1: the returned word is the stored word with enabled lanes replaced by wr_data.
  - BYPASS=0: the returned word is the pre-write contents.
- rd_data holds its last value while rd_valid=0; it is not cleared between reads.

## Timing
- READ_LATENCY=1: the read is sampled at edge N; rd_data/rd_valid update at edge N, visible in cycle N+1.
- READ_LATENCY=2: an extra output register stage is added; the result is visible one cycle later.
- Fully pipelined: back-to-back reads every cycle produce back-to-back rd_valid with no bubbles.
- Write data is visible to a non-colliding read issued on the next cycle.
- init_done rises exactly DEPTH cycles after the first rising edge with rst_n=1.
- rst_n assertion clears outputs immediately, without waiting for clk. Deassertion is synchronised by the integrator.

## Structure
- Shared package sram_pkg holds:
  - the byte-lane width constant (8);
  - the BYPASS encoding constants;
  - the FSM state encoding (CLEAR, READY).
- Sub-module sram_read_pipe holds the READ_LATENCY-deep valid/data register chain with async reset. It is reusable by future multi-port variants.
- The memory array is one reg array; there is no reset on its contents (clearing is done by the FSM only).

## Test plan
- Reset release, then poll: init_done=0 for 16 cycles, then 1. Reads of addresses 0..15 return 0 with rd_valid exactly 2 cycles after each rd_en.
- Write 16 random words with wr_be=4'hF, then read back-to-back: 16 consecutive rd_valid cycles with matching data and no gaps.
- Write 32'hAABBCCDD to addr 3, then 32'h11223344 with wr_be=4'b0101: a read returns 32'hAA22CC44.
- Same-cycle write 32'hDEADBEEF/read at addr 5 holding 32'h0:
  - BYPASS=1 returns 32'hDEADBEEF;
  - BYPASS=0 returns 32'h0, and the next read returns 32'hDEADBEEF.
- Assert rst_n mid-sweep at cycle 7: rd_valid=0 and rd_data=0 immediately. After release, init_done rises 16 cycles later, and previously written addresses read 0.
- READ_LATENCY=1, DEPTH=12:
  - a write to addr 13 is ignored;
  - a read of addr 13 returns 0 with rd_valid one cycle after rd_en;
  - rd_en/wr_en asserted during CLEAR produce no rd_valid and no write.
